z80_stack_sequencer: RTL and testbench
======================================

Name: z80_stack_sequencer

Overview:
- Sequences the two byte-wide memory transfers behind every 16-bit stack operation: pops for RET/POP, pushes for CALL/PUSH/RST.
- Sits between the instruction decoder/executor and the shared memory bus.
- The executor issues one word command; the block performs both bus cycles, tolerates wait states, and returns the popped word and the updated SP.
- Its address, SP and data results match the z80fi stack semantics: pop reads SP then SP+1, SP_out = SP+2, word = {rdata2, rdata}.

Parameters:
- WAIT_LIMIT, 0, max cycles a bus request may wait for mem_ack before abort; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy WAIT_LIMIT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_push  in  1  1 = push, 0 = pop.
- cmd_sp  in  16  SP value before the operation.
- cmd_wdata  in  16  word to push (ignored on pop).
- mem_req  out  1  bus transfer request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid when mem_ack.
- mem_ack  in  1  transfer completes on an edge where mem_req && mem_ack.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on timeout.
- rdata  out  16  popped word, held until the next accept.
- sp_out  out  16  resulting SP, held until the next accept.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; mem_req=0; mem_wr=0; mem_addr=0; mem_wdata=0; done=0; err=0; rdata=0; sp_out=0; wait counter 0.
- Reset is asynchronous and active-low. Asserting it mid-operation returns the block to IDLE immediately and drops mem_req; the partial transfer is abandoned with no done pulse.
- States are IDLE, XFER1, XFER2, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op, sp and wdata, then go to XFER1. mem_req rises the following cycle.
- XFER1, pop: mem_addr=sp, read. The acked byte goes to rdata[7:0].
- XFER1, push: mem_addr=sp-1, mem_wdata=wdata[15:8], write.
- XFER2, pop: mem_addr=sp+1, read. The acked byte goes to rdata[15:8].
- XFER2, push: mem_addr=sp-2, mem_wdata=wdata[7:0], write.
- The transition XFER1 -> XFER2 happens on the ack edge. mem_req stays high continuously across both transfers, with no idle cycle between them.
- mem_addr, mem_wr and mem_wdata are stable while mem_req=1 and ack is absent.
- FIN:
  - mem_req=0 and done=1 for exactly one cycle.
  - sp_out = sp+2 for a pop, sp-2 for a push.
  - Next state is IDLE; cmd_ready is 0 in FIN.
- On push, rdata is left unchanged.
- All address arithmetic is modulo 2^16:
  - pop at sp=FFFF reads FFFF then 0000, sp_out=0001;
  - push at sp=0001 writes 0000 then FFFF, sp_out=FFFF.
- Latency with zero-wait ack: accept at edge 0; req in cycles 1 and 2; done in cycle 3. The next command can be accepted in cycle 4.
- Wait counter:
  - Cleared on each ack and on entry to XFER1.
  - Increments each cycle that mem_req=1 and mem_ack=0.
- Timeout: if WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT, go to FIN with err=1 and done=1. In that case sp_out=sp (unchanged) and rdata is unchanged.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Package z80_stack_pkg holds:
  - the state enum (IDLE, XFER1, XFER2, FIN);
  - the op constants OP_POP and OP_PUSH;
  - the SP delta constant SP_STEP = 16'h2.
- No sub-module is needed; the wait counter is inline.

Test Plan:
- Pop with zero wait: sp=1000, mem[1000]=34, mem[1001]=12, ack always high -> reads at 1000 then 1001, done in cycle 3, rdata=1234, sp_out=1002.
- Push with 2 wait states per transfer: sp=2000, wdata=ABCD -> writes AB@1FFF then CD@1FFE, address and data stable during waits, done in cycle 7, sp_out=1FFE.
- Wrap-around:
  - pop sp=FFFF -> addresses FFFF, 0000, sp_out=0001;
  - push sp=0001 -> addresses 0000, FFFF, sp_out=FFFF.
- Timeout with WAIT_LIMIT=4 and ack never asserted -> mem_req high for 4 cycles, then done=1 and err=1, sp_out=cmd_sp, cmd_ready=1 the next cycle.
- Reset mid-op: assert reset_n=0 during XFER2 -> mem_req=0 asynchronously, no done pulse, all outputs at reset values; a new pop after release completes normally.
- Back-to-back commands: cmd_valid held high -> second accept occurs only in IDLE after done; a spurious ack during IDLE is ignored.

Source files
------------

// File: rtl/z80_stack_pkg.sv
// Shared types and constants for the Z80 16-bit stack transfer sequencer.
package z80_stack_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StXfer1,
        StXfer2,
        StFin
    } state_e;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    localparam logic [15:0] SP_STEP = 16'h2;

endpackage

// File: rtl/z80_stack_sequencer.sv
// Performs the two byte transfers of a 16-bit stack push or pop over a
// wait-stated memory bus, returning the popped word and the updated SP.
module z80_stack_sequencer
    import z80_stack_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_push,
    input  logic [15:0] cmd_sp,
    input  logic [15:0] cmd_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] sp_out
);

    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic              op_q;
    logic [15:0]       sp_q;
    logic [15:0]       wdata_q;
    logic [7:0]        lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [15:0]       rdata_q;
    logic [15:0]       sp_out_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout;

    assign cnt_inc = cnt_q + CntOne;
    // Abort when this stalled cycle would bring the count up to the limit.
    assign timeout = (WAIT_LIMIT != 0) && (cnt_inc == LimitCnt);

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = StXfer1;
                end
            end
            StXfer1: begin
                mem_req = 1'b1;
                mem_wr  = op_q;
                if (op_q == OP_PUSH) begin
                    mem_addr  = sp_q - 16'h1;
                    mem_wdata = wdata_q[15:8];
                end else begin
                    mem_addr = sp_q;
                end
                if (mem_ack) begin
                    state_d = StXfer2;
                end else if (timeout) begin
                    state_d = StFin;
                end
            end
            StXfer2: begin
                mem_req = 1'b1;
                mem_wr  = op_q;
                if (op_q == OP_PUSH) begin
                    mem_addr  = sp_q - SP_STEP;
                    mem_wdata = wdata_q[7:0];
                end else begin
                    mem_addr = sp_q + 16'h1;
                end
                if (mem_ack || timeout) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OP_POP;
            sp_q     <= 16'h0000;
            wdata_q  <= 16'h0000;
            lo_q     <= 8'h00;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0000;
            sp_out_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_push;
                        sp_q    <= cmd_sp;
                        wdata_q <= cmd_wdata;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StXfer1, StXfer2: begin
                    if (mem_ack) begin
                        cnt_q <= '0;
                        // Low byte is staged so a timeout in the second
                        // transfer leaves the visible rdata untouched.
                        if (op_q == OP_POP) begin
                            if (state_q == StXfer1) begin
                                lo_q <= mem_rdata;
                            end else begin
                                rdata_q <= {mem_rdata, lo_q};
                            end
                        end
                        if (state_q == StXfer2) begin
                            sp_out_q <= (op_q == OP_PUSH) ? sp_q - SP_STEP : sp_q + SP_STEP;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout) begin
                            err_q    <= 1'b1;
                            sp_out_q <= sp_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata  = rdata_q;
    assign sp_out = sp_out_q;

endmodule

// File: tb/tb_z80_stack_sequencer.sv
// Self-checking bench: vector table plus scoreboarded bus and result checks.
module tb_z80_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_push = 1'b0;
    logic [15:0] cmd_sp = 16'h0000;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] sp_out;

    always #5 clk = ~clk;

    z80_stack_sequencer #(
        .WAIT_LIMIT(4),
        .CNT_W     (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_push (cmd_push),
        .cmd_sp   (cmd_sp),
        .cmd_wdata(cmd_wdata),
        .mem_req  (mem_req),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .sp_out   (sp_out)
    );

    typedef struct {
        logic        push;
        logic [15:0] sp;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] exp_rdata;
        logic [15:0] exp_sp;
        logic        exp_err;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [15:0] a1;
        logic [7:0]  d1;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        logic [15:0] sp;
        logic        err;
        int          lat;
    } res_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } tx_t;

    res_t res_q[$];
    tx_t  tx_q[$];
    int   acc_q[$];

    logic [7:0] mem [logic [15:0]];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    logic spur = 1'b0;
    logic stall = 1'b0;
    logic        s_wr = 1'b0;
    logic [15:0] s_addr = 16'h0000;
    logic [7:0]  s_wdata = 8'h00;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance tracking, result scoreboard and the wait-stated memory model.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack = 1'b0;
            wcnt = 0;
            stall = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
            if (done) begin
                done_cnt++;
                if (res_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    res_t r;
                    int a;
                    r = res_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rdata", 32'(rdata), 32'(r.rdata));
                    chk("sp_out", 32'(sp_out), 32'(r.sp));
                    chk("err", 32'(err), 32'(r.err));
                    chk("latency", 32'(cyc - a), 32'(r.lat));
                end
            end
            if (mem_req) begin
                if (stall) begin
                    chk("stable_addr", 32'(mem_addr), 32'(s_addr));
                    chk("stable_wr", 32'(mem_wr), 32'(s_wr));
                    chk("stable_wdata", 32'(mem_wdata), 32'(s_wdata));
                end
                if (wcnt >= wait_cfg) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd(mem_addr);
                    if (tx_q.size() == 0) begin
                        chk("unexpected_xfer", 32'(mem_req), 32'(0));
                    end else begin
                        tx_t t;
                        t = tx_q.pop_front();
                        chk("xfer_wr", 32'(mem_wr), 32'(t.wr));
                        chk("xfer_addr", 32'(mem_addr), 32'(t.addr));
                        if (t.wr) chk("xfer_wdata", 32'(mem_wdata), 32'(t.data));
                    end
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    tx_cnt++;
                    wcnt = 0;
                    stall = 1'b0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                    stall = 1'b1;
                    s_addr = mem_addr;
                    s_wr = mem_wr;
                    s_wdata = mem_wdata;
                end
            end else begin
                mem_ack = spur;
                mem_rdata = 8'h00;
                wcnt = 0;
                stall = 1'b0;
            end
        end
    end

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(name, 32'(0), 32'(1));
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push_expect(input vec_t v);
        res_q.push_back('{rdata: v.exp_rdata, sp: v.exp_sp, err: v.exp_err, lat: v.lat});
        if (!v.exp_err) begin
            tx_q.push_back('{wr: v.push, addr: v.a0, data: v.d0});
            tx_q.push_back('{wr: v.push, addr: v.a1, data: v.d1});
        end
    endtask

    task automatic send(input vec_t v);
        @(posedge clk);
        #1;
        cmd_push  = v.push;
        cmd_sp    = v.sp;
        cmd_wdata = v.wdata;
        wait_cfg  = v.waits;
        cmd_valid = 1'b1;
        push_expect(v);
        wait_accept();
        wait_done("done_timeout");
        @(negedge clk);
        chk("ready_after_done", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        int base;
        int d1;
        int dc;

        vecs[0] = '{1'b0, 16'h1000, 16'h0000, 0, 16'h1234, 16'h1002, 1'b0,
                    16'h1000, 8'h00, 16'h1001, 8'h00, 3};
        vecs[1] = '{1'b1, 16'h2000, 16'hABCD, 2, 16'h1234, 16'h1FFE, 1'b0,
                    16'h1FFF, 8'hAB, 16'h1FFE, 8'hCD, 7};
        vecs[2] = '{1'b0, 16'h1FFE, 16'h0000, 1, 16'hABCD, 16'h2000, 1'b0,
                    16'h1FFE, 8'h00, 16'h1FFF, 8'h00, 5};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 0, 16'hBEEF, 16'h0001, 1'b0,
                    16'hFFFF, 8'h00, 16'h0000, 8'h00, 3};
        vecs[4] = '{1'b1, 16'h0001, 16'h5AA5, 0, 16'hBEEF, 16'hFFFF, 1'b0,
                    16'h0000, 8'h5A, 16'hFFFF, 8'hA5, 3};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 0, 16'h5AA5, 16'h0001, 1'b0,
                    16'hFFFF, 8'h00, 16'h0000, 8'h00, 3};
        vecs[6] = '{1'b0, 16'h1000, 16'h0000, 3, 16'h1234, 16'h1002, 1'b0,
                    16'h1000, 8'h00, 16'h1001, 8'h00, 9};
        vecs[7] = '{1'b0, 16'h3000, 16'h0000, 1000, 16'h1234, 16'h3000, 1'b1,
                    16'h0000, 8'h00, 16'h0000, 8'h00, 5};
        vecs[8] = '{1'b1, 16'h4000, 16'h1111, 1000, 16'h1234, 16'h4000, 1'b1,
                    16'h0000, 8'h00, 16'h0000, 8'h00, 5};

        mem[16'h1000] = 8'h34;
        mem[16'h1001] = 8'h12;
        mem[16'hFFFF] = 8'hEF;
        mem[16'h0000] = 8'hBE;

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_mem_wr", 32'(mem_wr), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_sp_out", 32'(sp_out), 32'(0));
        #10 reset_n = 1'b1;

        foreach (vecs[i]) send(vecs[i]);

        // Reset asserted while the second transfer is stalled.
        @(posedge clk);
        #1;
        cmd_push = 1'b0;
        cmd_sp = 16'h1000;
        wait_cfg = 3;
        cmd_valid = 1'b1;
        tx_q.push_back('{wr: 1'b0, addr: 16'h1000, data: 8'h00});
        tx_q.push_back('{wr: 1'b0, addr: 16'h1001, data: 8'h00});
        base = tx_cnt;
        wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_cnt == base + 1) break;
        end
        repeat (2) @(negedge clk);
        chk("mid_req", 32'(mem_req), 32'(1));
        chk("mid_addr", 32'(mem_addr), 32'(16'h1001));
        dc = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'(0));
        chk("arst_mem_addr", 32'(mem_addr), 32'(0));
        chk("arst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_rdata", 32'(rdata), 32'(0));
        chk("arst_sp_out", 32'(sp_out), 32'(0));
        tx_q.delete();
        acc_q.delete();
        res_q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt), 32'(dc));
        send(vecs[0]);

        // Back-to-back with cmd_valid held high.
        @(posedge clk);
        #1;
        cmd_push = 1'b0;
        cmd_sp = 16'h1000;
        wait_cfg = 0;
        cmd_valid = 1'b1;
        push_expect(vecs[0]);
        push_expect(vecs[0]);
        wait_done("b2b_done1");
        chk("ready_in_fin", 32'(cmd_ready), 32'(0));
        d1 = cyc;
        @(negedge clk);
        chk("b2b_ready_idle", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done("b2b_done2");
        chk("b2b_spacing", 32'(cyc - d1), 32'(4));

        // Spurious ack while idle must be ignored.
        @(posedge clk);
        #1 spur = 1'b1;
        dc = done_cnt;
        repeat (3) begin
            @(negedge clk);
            chk("spur_mem_req", 32'(mem_req), 32'(0));
            chk("spur_ready", 32'(cmd_ready), 32'(1));
        end
        chk("spur_no_done", 32'(done_cnt), 32'(dc));
        @(posedge clk);
        #1 spur = 1'b0;
        send(vecs[0]);

        repeat (2) @(negedge clk);
        chk("leftover_results", 32'(res_q.size()), 32'(0));
        chk("leftover_xfers", 32'(tx_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
